// File: rtl/calc_share_arbiter.sv
// ---------------------------------------------------------------------------
// calc_share_arbiter
//
// Shares one WIDTH-bit calculator ALU (add / sub / or / compare) between two
// requesters. A round-robin grant picks which requester may hand over an
// operation. A three-state FSM then sequences that operation:
//   IDLE : offer ready to the grant target and capture operands on handshake
//   EXEC : evaluate the ALU on the captured operands and register the result
//   RESP : present the result until the consumer takes it
// The block sits between the switch/IO capture logic and the display-output
// register of the calculator top.
//
// Parameters
//   WIDTH        operand and result width in bits (default 4)
//
// Ports
//   clock        single clock; all state updates on the rising edge
//   clear        synchronous active-high reset, priority over every state
//   req0_valid   requester 0 has an operation pending
//   req0_ready   requester 0 operation accepted this cycle (with valid)
//   req0_a/b     requester 0 operands
//   req0_op      requester 0 opcode (00 add, 01 sub, 10 or, 11 compare)
//   req1_*       same set of signals for requester 1
//   resp_valid   result available
//   resp_ready   consumer accepts the result (only looked at in RESP)
//   resp_result  ALU result
//   resp_id      requester that issued the result
//   busy         high whenever the FSM is not in IDLE
//   resp_flag    only with CALC_SHARE_ARBITER_FLAGS_EN defined: carry for
//                add, borrow for sub, 0 for or/compare
//
// Configuration macro
//   CALC_SHARE_ARBITER_FLAGS_EN  adds the resp_flag output and its logic
// ---------------------------------------------------------------------------
module calc_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_id,
  output logic             busy
`ifdef CALC_SHARE_ARBITER_FLAGS_EN
  ,
  output logic             resp_flag
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_code;
  logic             op_id;

  logic             target;
  logic             accept0;
  logic             accept1;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] sum_lo;
  logic [WIDTH-1:0] diff_lo;

`ifdef CALC_SHARE_ARBITER_FLAGS_EN
  logic             carry;
  logic             borrow;
  logic             alu_flag;
`endif

  // Grant target: a lone valid requester always wins; otherwise (both or
  // neither valid) the requester that was not granted last time is offered
  // ready, which gives strict alternation under continuous contention.
  always_comb begin
    target = ~last_grant;
    if (req0_valid && !req1_valid) begin
      target = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      target = 1'b1;
    end
  end

  // Ready is only ever offered from IDLE, and only to the grant target.
  assign req0_ready = (state == IDLE) && !target;
  assign req1_ready = (state == IDLE) &&  target;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  // Extend the add/sub by one bit when flags are built so the top bit gives
  // the carry (add) or the unsigned borrow (sub) directly.
`ifdef CALC_SHARE_ARBITER_FLAGS_EN
  assign {carry,  sum_lo}  = {1'b0, op_a} + {1'b0, op_b};
  assign {borrow, diff_lo} = {1'b0, op_a} - {1'b0, op_b};
`else
  assign sum_lo  = op_a + op_b;
  assign diff_lo = op_a - op_b;
`endif

  // ALU evaluated from the captured operands only, never from the live
  // request inputs, so requesters may change them after the accept edge.
  always_comb begin
    alu_result = '0;
    case (op_code)
      OP_ADD:  alu_result = sum_lo;
      OP_SUB:  alu_result = diff_lo;
      OP_OR:   alu_result = op_a | op_b;
      OP_CMP:  alu_result = (op_a == op_b) ? '0 : WIDTH'(1);
      default: alu_result = '0;
    endcase
  end

`ifdef CALC_SHARE_ARBITER_FLAGS_EN
  always_comb begin
    alu_flag = 1'b0;
    case (op_code)
      OP_ADD:  alu_flag = carry;
      OP_SUB:  alu_flag = borrow;
      default: alu_flag = 1'b0;
    endcase
  end
`endif

  // Sequencing FSM with all outputs registered. clear wins in every state
  // and discards any operation in flight without producing a response.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      op_a        <= '0;
      op_b        <= '0;
      op_code     <= 2'b00;
      op_id       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_id     <= 1'b0;
      busy        <= 1'b0;
`ifdef CALC_SHARE_ARBITER_FLAGS_EN
      resp_flag   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept0) begin
            op_a       <= req0_a;
            op_b       <= req0_b;
            op_code    <= req0_op;
            op_id      <= 1'b0;
            last_grant <= 1'b0;
            busy       <= 1'b1;
            state      <= EXEC;
          end else if (accept1) begin
            op_a       <= req1_a;
            op_b       <= req1_b;
            op_code    <= req1_op;
            op_id      <= 1'b1;
            last_grant <= 1'b1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end

        EXEC: begin
          resp_result <= alu_result;
          resp_id     <= op_id;
`ifdef CALC_SHARE_ARBITER_FLAGS_EN
          resp_flag   <= alu_flag;
`endif
          resp_valid  <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          // Result stays put until consumed; the next accept can only
          // happen from IDLE, one cycle after this handshake.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
